updown_counter: RTL and testbench
=================================

# updown_counter

Parametrised up/down counter with programmable terminal value, wrap or saturate mode, synchronous parallel load, zero flag and terminal-count pulse. It succeeds the fixed 4-bit free-running up/down counters in the lab designs. It serves as the general counting primitive for timers, address generators and event counters in the same clock domain.

## Interface
- `WIDTH`, 4: counter width in bits, 2..32.
- `MAX_VALUE`, 2**WIDTH-1: terminal count; counter range is 0..MAX_VALUE inclusive; must be ≥1 and ≤2**WIDTH-1.
- `SATURATE`, 0: 0 = wrap at boundaries, 1 = hold at boundaries.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  active-high count enable.
- `up_down`  in  1  direction: 1 = increment, 0 = decrement; sampled only when counting.
- `load`  in  1  active-high synchronous parallel load.
- `load_value`  in  WIDTH  value loaded when `load`=1.
- `count`  out  WIDTH  registered counter value.
- `z_flag`  out  1  1 when `count`==0, decoded from the register.
- `tc`  out  1  registered one-cycle terminal-count pulse.

## Operation
- Priority per rising edge: reset_n low > load > enable > hold.
- Reset (asynchronous, immediate on reset_n falling): `count`=0, `tc`=0, hence `z_flag`=1. Release is synchronous to `clock`; the first update occurs on the first rising edge with reset_n high.
- Load: `count` ← min(`load_value`, MAX_VALUE); `tc` ← 0. Load applies whether or not `enable` is high.
- Count, up, not at MAX_VALUE: `count`+1, `tc` ← 0.
- Count, down, not at 0: `count`-1, `tc` ← 0.
- Count up at MAX_VALUE: SATURATE=0 sets `count` ← 0; SATURATE=1 holds at MAX_VALUE. In both cases `tc` ← 1.
- Count down at 0: SATURATE=0 sets `count` ← MAX_VALUE; SATURATE=1 holds at 0. In both cases `tc` ← 1.
- Hold (enable=0, load=0): `count` unchanged, `tc` ← 0.
- Direction changes take effect immediately, with no dead cycle.
- Arithmetic: compute in WIDTH bits. The comparison against MAX_VALUE is exact, and no value above MAX_VALUE is ever reachable.

## Timing
- Latency: one cycle from sampled `enable`/`load` to the new `count`.
- `tc` is high in the same cycle the post-boundary `count` is visible, for exactly one cycle per boundary event. In SATURATE=1 mode it repeats on every enabled cycle pushing past the boundary.
- `z_flag` is combinational from the `count` register with no extra latency, and is glitch-free relative to `count`.
- `load` and boundary in the same cycle: load wins and `tc`=0.
- Reset asserted mid-count: outputs go to reset values without waiting for a clock edge.

## Configuration
- Macro: `UPDOWN_COUNTER_LOAD_EN`.
  - Defined: `load`/`load_value` operate as described.
  - Undefined: load logic is not compiled. The ports remain but are ignored, and priority reduces to reset > enable > hold.

## Test plan
- Reset: drive reset_n=0 mid-clock with count=7 → count=0, z_flag=1, tc=0 before the next edge; after release with enable=0, outputs hold.
- Wrap up (WIDTH=4, MAX_VALUE=9, SATURATE=0): enable=1, up_down=1 for 10 cycles from 0 → count 1..9 then 0, with tc=1 only in the count=0 cycle.
- Wrap down: from 0, up_down=0, one enabled cycle → count=9, tc=1; next cycle count=8, tc=0.
- Saturate (SATURATE=1, MAX_VALUE=9): count up from 8 for 3 cycles → 9,9,9 with tc=0,1,1. Then count down from 0 → 0 and tc=1.
- Load (macro defined): load_value=12, load=1, enable=1 at count=9 → count=9 (clamped), tc=0. Then load_value=3 → count=3. With the macro undefined, the same stimulus produces normal counting instead.
- Direction toggle: alternate up_down every cycle from 5 → 6,5,6,5. Drop enable → count holds and tc=0.

Source files
------------

// File: rtl/updown_counter.sv
// Up/down counter with a programmable terminal value, wrap or saturate at the boundaries, a zero flag and a terminal-count pulse.
// The parallel load (load/load_value) is compiled only when UPDOWN_COUNTER_LOAD_EN is defined.
module updown_counter #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
  parameter bit              SATURATE  = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             z_flag,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             load_active;
  logic [WIDTH-1:0] load_clamped;

`ifdef UPDOWN_COUNTER_LOAD_EN
  assign load_active  = load;
  // A load above the terminal value must not leave the counter out of range
  assign load_clamped = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
`else
  logic unused_load_inputs;
  assign unused_load_inputs = ^{load, load_value};
  assign load_active        = 1'b0;
  assign load_clamped       = '0;
`endif

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load_active) begin
      count_d = load_clamped;
    end else if (enable) begin
      if (up_down) begin
        if (count_q == MAX_VALUE) begin
          tc_d    = 1'b1;
          count_d = SATURATE ? MAX_VALUE : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          tc_d    = 1'b1;
          count_d = SATURATE ? '0 : MAX_VALUE;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count  = count_q;
  assign tc     = tc_q;
  assign z_flag = (count_q == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: a wrapping and a saturating instance (WIDTH=4, MAX_VALUE=9) share one stimulus.
// Table vectors, hand-written corner sequences, then random stimulus against an arithmetic reference model.
module tb_updown_counter;
  localparam int W    = 4;
  localparam int MAXV = 9;
`ifdef UPDOWN_COUNTER_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset_n, enable, up_down, load;
  logic [W-1:0] load_value;
  logic [W-1:0] count0, count1;
  logic         z0, z1, tc0, tc1;

  always #5 clock = ~clock;

  updown_counter #(.WIDTH(W), .MAX_VALUE(4'd9), .SATURATE(1'b0)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .count(count0), .z_flag(z0), .tc(tc0)
  );

  updown_counter #(.WIDTH(W), .MAX_VALUE(4'd9), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset_n(reset_n), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .count(count1), .z_flag(z1), .tc(tc1)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: index 0 wraps, index 1 saturates
  int m_count[2];
  bit m_tc[2];

  typedef struct {
    bit         en;
    bit         up;
    bit         ld;
    logic [3:0] lv;
    int         c0;
    int         t0;
    int         c1;
    int         t1;
  } vec_t;
  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_both(input string tag, input int c0, input int t0, input int c1, input int t1);
    check({tag, " wrap.count"}, 32'(count0), c0);
    check({tag, " wrap.tc"},    32'(tc0),    t0);
    check({tag, " wrap.z"},     32'(z0),     (c0 == 0) ? 1 : 0);
    check({tag, " sat.count"},  32'(count1), c1);
    check({tag, " sat.tc"},     32'(tc1),    t1);
    check({tag, " sat.z"},      32'(z1),     (c1 == 0) ? 1 : 0);
    $display("[TB] %s en=%0b up=%0b ld=%0b lv=%0d -> wrap %0d/tc%0b sat %0d/tc%0b",
             tag, enable, up_down, load, load_value, count0, tc0, count1, tc1);
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int n;
      if (!reset_n) begin
        m_count[i] = 0;
        m_tc[i]    = 1'b0;
      end else if (LOAD_EN && load) begin
        m_count[i] = (int'(load_value) > MAXV) ? MAXV : int'(load_value);
        m_tc[i]    = 1'b0;
      end else if (enable) begin
        n = m_count[i] + (up_down ? 1 : -1);
        if (n > MAXV || n < 0) begin
          m_tc[i] = 1'b1;
          if (i == 1) n = up_down ? MAXV : 0;
          else        n = up_down ? 0 : MAXV;
        end else begin
          m_tc[i] = 1'b0;
        end
        m_count[i] = n;
      end else begin
        m_tc[i] = 1'b0;
      end
    end
  endtask

  // Inputs are set 1 time unit after an edge; outputs are sampled at the same point
  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit en, input bit up, input bit ld, input logic [3:0] lv);
    enable     = en;
    up_down    = up;
    load       = ld;
    load_value = lv;
  endtask

  task automatic do_reset();
    #3;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 0;
      m_tc[i]    = 1'b0;
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_up(input int n);
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    m_count[0] = 0; m_count[1] = 0; m_tc[0] = 1'b0; m_tc[1] = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_both("reset", 0, 0, 0, 0);
    reset_n = 1'b1;
    step();
    check_both("hold_after_reset", 0, 0, 0, 0);

    // Vector table, starting from count 0 in both instances
    for (int k = 0; k < 9; k++) vecs[k] = '{1'b1, 1'b1, 1'b0, 4'd0, k + 1, 0, k + 1, 0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'd0, 0, 1, 9, 1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd0, 9, 1, 8, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 4'd0, 8, 0, 7, 0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 4'd0, 8, 0, 7, 0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 4'd0, 9, 0, 8, 0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 4'd0, 0, 1, 9, 0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 4'd0, 1, 0, 9, 1};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 4'd0, 2, 0, 9, 1};
`ifdef UPDOWN_COUNTER_LOAD_EN
    vecs[17] = '{1'b1, 1'b1, 1'b1, 4'd12, 9, 0, 9, 0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 4'd3,  3, 0, 3, 0};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 4'd0,  0, 0, 0, 0};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 4'd0,  9, 1, 0, 1};
`else
    vecs[17] = '{1'b1, 1'b1, 1'b1, 4'd12, 3, 0, 9, 1};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 4'd3,  3, 0, 9, 0};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 4'd0,  2, 0, 8, 0};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 4'd0,  1, 0, 7, 0};
`endif
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].lv);
      step();
      check_both($sformatf("vec%0d", i), vecs[i].c0, vecs[i].t0, vecs[i].c1, vecs[i].t1);
    end

    // Saturate/wrap at the top, starting from 8
    do_reset();
    run_up(8);
    check_both("sat_start8", 8, 0, 8, 0);
    step(); check_both("sat_up1", 9, 0, 9, 0);
    step(); check_both("sat_up2", 0, 1, 9, 1);
    step(); check_both("sat_up3", 1, 0, 9, 1);

    // Down from 0
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    step(); check_both("down_from0", 9, 1, 0, 1);
    step(); check_both("down_again", 8, 0, 0, 1);

    // Direction toggle every cycle from 5, then drop enable
    do_reset();
    run_up(5);
    check_both("toggle_start5", 5, 0, 5, 0);
    drive(1'b1, 1'b1, 1'b0, 4'd0); step(); check_both("toggle1", 6, 0, 6, 0);
    drive(1'b1, 1'b0, 1'b0, 4'd0); step(); check_both("toggle2", 5, 0, 5, 0);
    drive(1'b1, 1'b1, 1'b0, 4'd0); step(); check_both("toggle3", 6, 0, 6, 0);
    drive(1'b1, 1'b0, 1'b0, 4'd0); step(); check_both("toggle4", 5, 0, 5, 0);
    drive(1'b0, 1'b1, 1'b0, 4'd0); step(); check_both("toggle_hold1", 5, 0, 5, 0);
    step(); check_both("toggle_hold2", 5, 0, 5, 0);

    // Asynchronous reset mid-cycle at count 7, then with tc high
    do_reset();
    run_up(7);
    check_both("pre_reset7", 7, 0, 7, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_both("async_reset_at7", 0, 0, 0, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    run_up(10);
    check_both("pre_reset_tc", 0, 1, 9, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_both("async_reset_tc", 0, 0, 0, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    step(); check_both("release_hold1", 0, 0, 0, 0);
    step(); check_both("release_hold2", 0, 0, 0, 0);

    // Random stimulus against the reference model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      drive(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom));
      step();
      check_both($sformatf("rand%0d", i), m_count[0], m_tc[0], m_count[1], m_tc[1]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
